// File: rtl/rename_alias_if.sv
// rename_alias_if: issue-slot, CDB snoop and RS-facing operand bundle for the rename alias table.
interface rename_alias_if;
    logic        stall, valid1, valid2, regwrite1, regwrite2;
    logic [4:0]  rs1, rt1, rd1, rs2, rt2, rd2;
    logic        alu1_wr, alu2_wr, ld1_wr, ld2_wr;
    logic [4:0]  alu1_res_tag, alu2_res_tag, ld1_res_tag, ld2_res_tag;
    logic [31:0] alu1_res, alu2_res, ld1_res, ld2_res;
    logic [4:0]  rs1_tag, rt1_tag, rs2_tag, rt2_tag, dest1_tag, dest2_tag;
    logic        ready_rs1, ready_rt1, ready_rs2, ready_rt2, full;
    logic [31:0] val1_1, val2_1, val1_2, val2_2;

    modport master (
        output stall, valid1, valid2, regwrite1, regwrite2, rs1, rt1, rd1, rs2, rt2, rd2,
               alu1_wr, alu2_wr, ld1_wr, ld2_wr, alu1_res_tag, alu2_res_tag, ld1_res_tag, ld2_res_tag,
               alu1_res, alu2_res, ld1_res, ld2_res,
        input  rs1_tag, rt1_tag, rs2_tag, rt2_tag, dest1_tag, dest2_tag,
               ready_rs1, ready_rt1, ready_rs2, ready_rt2, full, val1_1, val2_1, val1_2, val2_2
    );
    modport slave (
        input  stall, valid1, valid2, regwrite1, regwrite2, rs1, rt1, rd1, rs2, rt2, rd2,
               alu1_wr, alu2_wr, ld1_wr, ld2_wr, alu1_res_tag, alu2_res_tag, ld1_res_tag, ld2_res_tag,
               alu1_res, alu2_res, ld1_res, ld2_res,
        output rs1_tag, rt1_tag, rs2_tag, rt2_tag, dest1_tag, dest2_tag,
               ready_rs1, ready_rt1, ready_rs2, ready_rt2, full, val1_1, val2_1, val1_2, val2_2
    );
endinterface

// File: rtl/rename_alias_table.sv
// rename_alias_table: dual-issue rename with per-register value/pending/tag, tag allocation
// and same-cycle CDB bypass on operand lookup.
module rename_alias_table #(
    parameter int NTAGS  = 32,
    parameter int MARGIN = 2
) (
    input logic clk,
    input logic rst,
    rename_alias_if.slave io
);
    typedef struct packed {
        logic [4:0]  tag;
        logic        rdy;
        logic [31:0] val;
    } src_t;

    logic [31:0] vals [32];
    logic [4:0]  tags [32];
    logic [31:0] pend;
    logic [4:0]  next_tag, tag2;
    logic [5:0]  inflight;
    logic        alloc1, alloc2;
    logic [3:0]  bwr;
    logic [4:0]  btag [4];
    logic [31:0] bdat [4];
    src_t        s_rs1, s_rt1, s_rs2, s_rt2;

    // bus index 0 has highest priority: ALU1 > ALU2 > LD1 > LD2
    assign bwr     = {io.ld2_wr, io.ld1_wr, io.alu2_wr, io.alu1_wr};
    assign btag[0] = io.alu1_res_tag;
    assign btag[1] = io.alu2_res_tag;
    assign btag[2] = io.ld1_res_tag;
    assign btag[3] = io.ld2_res_tag;
    assign bdat[0] = io.alu1_res;
    assign bdat[1] = io.alu2_res;
    assign bdat[2] = io.ld1_res;
    assign bdat[3] = io.ld2_res;

    assign io.full      = inflight > 6'(NTAGS - 1 - MARGIN);
    assign alloc1       = io.valid1 & io.regwrite1 & (|io.rd1) & ~io.stall & ~io.full;
    assign alloc2       = io.valid2 & io.regwrite2 & (|io.rd2) & ~io.stall & ~io.full;
    assign tag2         = next_tag + 5'(alloc1);
    assign io.dest1_tag = next_tag;
    assign io.dest2_tag = tag2;

    function automatic src_t lookup(input logic [4:0] r, input logic fwd);
        src_t s;
        s = '{tag: tags[r], rdy: ~pend[r], val: pend[r] ? 32'd0 : vals[r]};
        if (pend[r])
            for (int b = 3; b >= 0; b--)
                if (bwr[b] && btag[b] == tags[r]) begin
                    s.rdy = 1'b1;
                    s.val = bdat[b];
                end
        if (fwd) s = '{tag: next_tag, rdy: 1'b0, val: 32'd0};
        if (r == 5'd0) s = '{tag: 5'd0, rdy: 1'b1, val: 32'd0};
        return s;
    endfunction

    assign s_rs1 = lookup(io.rs1, 1'b0);
    assign s_rt1 = lookup(io.rt1, 1'b0);
    assign s_rs2 = lookup(io.rs2, alloc1 && io.rs2 == io.rd1);
    assign s_rt2 = lookup(io.rt2, alloc1 && io.rt2 == io.rd1);

    assign {io.rs1_tag, io.ready_rs1, io.val1_1} = s_rs1;
    assign {io.rt1_tag, io.ready_rt1, io.val2_1} = s_rt1;
    assign {io.rs2_tag, io.ready_rs2, io.val1_2} = s_rs2;
    assign {io.rt2_tag, io.ready_rt2, io.val2_2} = s_rt2;

    // Later assignments win: allocation overrides retire, slot 2 overrides slot 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            next_tag <= '0;
            inflight <= '0;
            for (int i = 0; i < 32; i++) begin
                vals[i] <= '0;
                tags[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++)
                for (int b = 3; b >= 0; b--)
                    if (bwr[b] && pend[i] && btag[b] == tags[i]) begin
                        vals[i] <= bdat[b];
                        pend[i] <= 1'b0;
                    end
            if (alloc1) begin
                pend[io.rd1] <= 1'b1;
                tags[io.rd1] <= next_tag;
            end
            if (alloc2) begin
                pend[io.rd2] <= 1'b1;
                tags[io.rd2] <= tag2;
            end
            next_tag <= next_tag + 5'(alloc1) + 5'(alloc2);
            inflight <= inflight + 6'(alloc1) + 6'(alloc2) - 6'($countones(bwr));
        end
    end
endmodule
